// File: rtl/uram_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uram_pkg                                                              |
// | Shared UltraRAM geometry constants and an address helper.             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package uram_pkg;

   localparam int URAM_DATA_W = 72;
   localparam int URAM_ADDR_W = 23;
   localparam int URAM_BWE_W  = 9;
   localparam int URAM_RD_LAT = 1;

   // Drops the wrap bit of a FIFO pointer, leaving a zero-extended URAM address.
   function automatic logic [URAM_ADDR_W-1:0] ptr_to_addr(
      input logic [URAM_ADDR_W-1:0] ptr,
      input int                     depth_log2
   );
      logic [URAM_ADDR_W-1:0] mask;
      mask = (URAM_ADDR_W'(1) << depth_log2) - URAM_ADDR_W'(1);
      return ptr & mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uram_fifo_skid.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uram_fifo_skid                                                        |
// | Two-entry output buffer that catches URAM read data for the stream.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module uram_fifo_skid
   import uram_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [URAM_DATA_W-1:0] i_push_data,
   input  logic                   i_pop,
   output logic [URAM_DATA_W-1:0] o_data,
   output logic                   o_valid,
   output logic [1:0]             o_count
);

   logic [URAM_DATA_W-1:0] r_mem [2];
   logic                   r_head;
   logic [1:0]             r_count;
   logic                   w_tail;
   logic                   w_pop;

   // The head slot is never written while it is still being presented.
   assign w_tail  = r_head ^ r_count[0];
   assign w_pop   = i_pop && (r_count != 2'd0);
   assign o_data  = r_mem[r_head];
   assign o_valid = (r_count != 2'd0);
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[w_tail] <= i_push_data;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
      end
   end

endmodule
`default_nettype wire

// File: rtl/uram_fifo_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uram_fifo_ctrl                                                        |
// | Stream FIFO over one UltraRAM; URAM_FIFO_LEVEL_EN enables level and   |
// | almost_full reporting. Revision: 1.0                                  |
// +-----------------------------------------------------------------------+
module uram_fifo_ctrl
   import uram_pkg::*;
#(
   parameter int DEPTH_LOG2   = 12,
   parameter int AFULL_THRESH = 4000
)(
   input  logic                   clk,
   input  logic                   rst_async,
   input  logic [URAM_DATA_W-1:0] s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [URAM_DATA_W-1:0] m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [URAM_DATA_W-1:0] uram_din_a,
   output logic [URAM_BWE_W-1:0]  uram_bw_en_a,
   output logic [URAM_ADDR_W-1:0] uram_addr_a,
   output logic                   uram_en_a,
   output logic                   uram_we_a,
   output logic [URAM_ADDR_W-1:0] uram_addr_b,
   output logic                   uram_en_b,
   output logic                   uram_we_b,
   input  logic [URAM_DATA_W-1:0] uram_dout_b,
   output logic [DEPTH_LOG2+1:0]  level,
   output logic                   almost_full
);

   localparam int c_ptr_w = DEPTH_LOG2 + 1;
   localparam int c_lvl_w = DEPTH_LOG2 + 2;
   localparam logic [c_ptr_w-1:0] c_full = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [c_ptr_w-1:0]     r_wr_ptr;
   logic [c_ptr_w-1:0]     r_rd_ptr;
   logic [c_ptr_w-1:0]     w_occ;
   logic                   r_inflight;
   logic                   w_accept;
   logic                   w_issue;
   logic                   w_pop;
   logic                   w_buf_valid;
   logic [1:0]             w_buf_count;
   logic [1:0]             w_pending;
   logic [URAM_DATA_W-1:0] w_buf_data;

   assign w_occ    = r_wr_ptr - r_rd_ptr;
   assign s_ready  = !rst_async && (w_occ != c_full);
   assign w_accept = s_valid && s_ready;
   assign m_valid  = !rst_async && w_buf_valid;
   assign m_data   = w_buf_data;
   assign w_pop    = m_valid && m_ready;

   // Buffer slots left committed after this edge; crediting the pop keeps full rate.
   assign w_pending = w_buf_count + {1'b0, r_inflight} - {1'b0, w_pop};
   assign w_issue   = !rst_async && (w_occ != '0) && (w_pending < 2'd2);

   assign uram_en_a    = w_accept;
   assign uram_we_a    = w_accept;
   assign uram_bw_en_a = '1;
   assign uram_din_a   = s_data;
   assign uram_addr_a  = ptr_to_addr(URAM_ADDR_W'(r_wr_ptr), DEPTH_LOG2);
   assign uram_en_b    = w_issue;
   assign uram_we_b    = 1'b0;
   assign uram_addr_b  = ptr_to_addr(URAM_ADDR_W'(r_rd_ptr), DEPTH_LOG2);

   always_ff @(posedge clk) begin
      if (rst_async) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_inflight <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         r_inflight <= w_issue;
      end
   end

   uram_fifo_skid u_skid (
      .clk         (clk),
      .rst         (rst_async),
      .i_push      (r_inflight),
      .i_push_data (uram_dout_b),
      .i_pop       (w_pop),
      .o_data      (w_buf_data),
      .o_valid     (w_buf_valid),
      .o_count     (w_buf_count)
   );

`ifdef URAM_FIFO_LEVEL_EN
   localparam logic [c_lvl_w-1:0] c_afull = c_lvl_w'(AFULL_THRESH);

   logic [c_lvl_w-1:0] r_level;

   always_ff @(posedge clk) begin
      if (rst_async) begin
         r_level <= '0;
      end else begin
         r_level <= c_lvl_w'(w_occ) + c_lvl_w'(r_inflight) + c_lvl_w'(w_buf_count);
      end
   end

   assign level       = r_level;
   assign almost_full = !rst_async && (r_level >= c_afull);
`else
   logic [31:0] w_unused_thresh;
   assign w_unused_thresh = AFULL_THRESH;
   assign level           = '0;
   assign almost_full     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uram_fifo_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uram_fifo_ctrl                                                     |
// | Directed bench for uram_fifo_ctrl with a 1-cycle URAM model.          |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_uram_fifo_ctrl;

`ifdef URAM_FIFO_LEVEL_EN
   localparam bit c_lvl_on = 1'b1;
`else
   localparam bit c_lvl_on = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_async = 1'b1;
   logic [71:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [71:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [71:0] uram_din_a;
   logic [8:0]  uram_bw_en_a;
   logic [22:0] uram_addr_a;
   logic        uram_en_a;
   logic        uram_we_a;
   logic [22:0] uram_addr_b;
   logic        uram_en_b;
   logic        uram_we_b;
   logic [71:0] uram_dout_b;
   logic [5:0]  level;
   logic        almost_full;

   uram_fifo_ctrl #(.DEPTH_LOG2(4), .AFULL_THRESH(12)) dut (
      .clk(clk), .rst_async(rst_async),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .uram_din_a(uram_din_a), .uram_bw_en_a(uram_bw_en_a), .uram_addr_a(uram_addr_a),
      .uram_en_a(uram_en_a), .uram_we_a(uram_we_a),
      .uram_addr_b(uram_addr_b), .uram_en_b(uram_en_b), .uram_we_b(uram_we_b),
      .uram_dout_b(uram_dout_b),
      .level(level), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   logic [71:0] mem [16];
   always_ff @(posedge clk) begin
      if (uram_en_a && uram_we_a) mem[uram_addr_a[3:0]] <= uram_din_a;
      if (uram_en_b) uram_dout_b <= mem[uram_addr_b[3:0]];
   end

   int          checks = 0;
   int          failures = 0;
   int          accs = 0;
   int          pops = 0;
   int          cyc_n = 0;
   logic [3:0]  wr_idx = '0;
   logic [71:0] nxt = '0;
   bit          rnd = 1'b0;
   logic [71:0] q [$];

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_s_ready"}, s_ready, 1'b0);
      check({tag, "_m_valid"}, m_valid, 1'b0);
      check({tag, "_en_a"}, {uram_en_a, uram_we_a}, 2'b00);
      check({tag, "_en_b"}, uram_en_b, 1'b0);
      check({tag, "_afull"}, almost_full, 1'b0);
   endtask

   task automatic drive(input logic sv, input logic mr);
      logic [95:0] t;
      s_valid = sv;
      m_ready = mr;
      s_data  = nxt;
      #1;
      if (s_valid && s_ready && !rst_async) begin
         t   = {$urandom, $urandom, $urandom};
         nxt = rnd ? t[71:0] : nxt + 72'h1;
      end
   endtask

   // Scoreboard update for the settled cycle, then advance to the next negedge.
   task automatic score();
      if (rst_async) begin
         q.delete();
         wr_idx = '0;
      end else begin
         if (s_valid && s_ready) begin
            check("en_a", {uram_en_a, uram_we_a}, 2'b11);
            check("bw_en_a", uram_bw_en_a, 9'h1FF);
            check("addr_a", uram_addr_a, {19'b0, wr_idx});
            check("din_a", uram_din_a, s_data);
            q.push_back(s_data);
            wr_idx++;
            accs++;
         end else begin
            check("en_a_idle", {uram_en_a, uram_we_a}, 2'b00);
         end
         if (m_valid) begin
            if (q.size() == 0) begin
               check("m_valid_empty", m_valid, 1'b0);
            end else begin
               check("m_data", m_data, q[0]);
               if (m_ready) begin
                  void'(q.pop_front());
                  pops++;
               end
            end
         end
      end
      check("we_b", uram_we_b, 1'b0);
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic cyc(input logic sv, input logic mr);
      drive(sv, mr);
      score();
   endtask

   task automatic drain(input int bound);
      for (int i = 0; i < bound && q.size() != 0; i++) cyc(1'b0, 1'b1);
      check("drain_empty", 72'(q.size()), 72'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      // Reset held with traffic offered on both sides.
      rst_async = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1);
         check_reset("rst");
         check("rst_level", level, 6'd0);
         score();
      end
      rst_async = 1'b0;
      drive(1'b0, 1'b0);
      check("rel_s_ready", s_ready, 1'b1);
      score();

      // Five words, consumer always ready: first m_valid three cycles after accept.
      nxt = 72'h1; accs = 0; pops = 0;
      drive(1'b1, 1'b1);
      check("c0_s_ready", s_ready, 1'b1);
      check("c0_m_valid", m_valid, 1'b0);
      score();
      drive(1'b1, 1'b1);
      check("c1_issue", {uram_en_b, uram_addr_b}, {1'b1, 23'h0});
      check("c1_m_valid", m_valid, 1'b0);
      score();
      drive(1'b1, 1'b1);
      check("c2_m_valid", m_valid, 1'b0);
      score();
      drive(1'b1, 1'b1);
      check("c3_m_valid", m_valid, 1'b1);
      check("c3_m_data", m_data, 72'h1);
      score();
      cyc(1'b1, 1'b1);
      for (int i = 0; i < 20 && pops < 5; i++) cyc(1'b0, 1'b1);
      check("five_accs", 72'(accs), 72'd5);
      check("five_pops", 72'(pops), 72'd5);

      // Fill with the consumer stalled: 16 in URAM plus 2 already in the buffer.
      nxt = 72'h100; accs = 0;
      for (int i = 0; i < 24; i++) cyc(1'b1, 1'b0);
      check("fill_accs", 72'(accs), 72'd18);
      drive(1'b1, 1'b0);
      check("full_s_ready", s_ready, 1'b0);
      check("full_level", level, c_lvl_on ? 6'd18 : 6'd0);
      check("full_afull", almost_full, c_lvl_on);
      score();

      // From full, both sides streaming for 40 cycles across the pointer wrap.
      accs = 0; pops = 0;
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1);
      check("stream_accs", 72'(accs), 72'd39);
      check("stream_pops", 72'(pops), 72'd40);
      drain(60);
      drive(1'b0, 1'b1);
      check("stream_idle", m_valid, 1'b0);
      score();

      // 200 random words against a randomly stalling consumer.
      rnd = 1'b1; nxt = 72'h5A5A_0000_1234_0000_01; accs = 0; pops = 0;
      for (int i = 0; i < 3000 && accs < 200; i++) cyc(accs < 200, 1'($urandom_range(0, 1)));
      check("rand_accs", 72'(accs), 72'd200);
      drain(100);
      check("rand_pops", 72'(pops), 72'd200);
      rnd = 1'b0;

      // Reset with 7 words in URAM, 2 buffered, and one read in flight.
      nxt = 72'h600; accs = 0;
      for (int i = 0; i < 20 && accs < 9; i++) cyc(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
      check("pre_rst_level", level, c_lvl_on ? 6'd9 : 6'd0);
      drive(1'b0, 1'b1);
      check("pre_rst_m_valid", m_valid, 1'b1);
      check("pre_rst_issue", uram_en_b, 1'b1);
      score();
      rst_async = 1'b1;
      drive(1'b0, 1'b0);
      check_reset("mid_rst");
      score();
      drive(1'b0, 1'b0);
      check_reset("mid_rst2");
      check("mid_rst_level", level, 6'd0);
      score();
      rst_async = 1'b0;
      nxt = 72'hAA; pops = 0;
      drive(1'b1, 1'b1);
      check("post_rst_s_ready", s_ready, 1'b1);
      score();
      for (int i = 0; i < 10 && pops == 0; i++) cyc(1'b0, 1'b1);
      check("post_rst_pops", 72'(pops), 72'd1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);

      // almost_full boundary at 11 and 12 stored words.
      nxt = 72'h700; accs = 0;
      for (int i = 0; i < 20 && accs < 11; i++) cyc(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
      check("lvl11", level, c_lvl_on ? 6'd11 : 6'd0);
      check("afull11", almost_full, 1'b0);
      for (int i = 0; i < 5 && accs < 12; i++) cyc(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
      check("lvl12", level, c_lvl_on ? 6'd12 : 6'd0);
      check("afull12", almost_full, c_lvl_on);
      drain(40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
